// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the digital clock counter chain: gates the 1 Hz tick into
// sec/min/hour count enables in RUN, and steps one field from the UP button in set modes.
module clock_set_ctrl #(
  parameter int unsigned HOLD_TICKS    = 3,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       TICK,
  input  logic       SEC_CARRY,
  input  logic       MIN_CARRY,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic       SEC_EN,
  output logic       MIN_EN,
  output logic       HOUR_EN,
  output logic       SEC_CLR,
  output logic [1:0] MODE,
  output logic       DISP_HOUR_ON,
  output logic       DISP_MIN_ON
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);

  logic [1:0]    mode_q, mode_d;
  logic          sec_en_q, sec_en_d;
  logic          min_en_q, min_en_d;
  logic          hour_en_q, hour_en_d;
  logic          sec_clr_q, sec_clr_d;
  logic          disp_hour_q, disp_hour_d;
  logic          disp_min_q, disp_min_d;
  logic          mode_prev_q, mode_prev_d;
  logic          up_prev_q, up_prev_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idle_q, idle_d;

  logic mode_e, up_e, field_pulse, idle_expired;

  always_comb begin
    mode_e       = BTN_MODE & ~mode_prev_q;
    up_e         = BTN_UP & ~up_prev_q;
    field_pulse  = up_e | (BTN_UP & TICK & (hold_q >= HOLD_MAX));
    idle_expired = TICK & ~BTN_UP & (idle_q == IDLE_LAST);

    mode_d      = mode_q;
    sec_en_d    = 1'b0;
    min_en_d    = 1'b0;
    hour_en_d   = 1'b0;
    sec_clr_d   = 1'b0;
    disp_hour_d = 1'b1;
    disp_min_d  = 1'b1;
    hold_d      = hold_q;
    idle_d      = idle_q;
    mode_prev_d = BTN_MODE;
    up_prev_d   = BTN_UP;

    case (mode_q)
      ST_RUN: begin
        sec_en_d  = TICK;
        min_en_d  = TICK & SEC_CARRY;
        hour_en_d = TICK & SEC_CARRY & MIN_CARRY;
        hold_d    = '0;
        idle_d    = '0;
        if (mode_e) mode_d = ST_SET_HOUR;
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        // A mode edge wins over a coincident UP edge: leave the field untouched.
        if (mode_e) begin
          mode_d    = (mode_q == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
          sec_clr_d = (mode_q == ST_SET_MIN);
          hold_d    = '0;
          idle_d    = '0;
        end else if (idle_expired) begin
          mode_d    = ST_RUN;
          sec_clr_d = 1'b1;
          hold_d    = '0;
          idle_d    = '0;
        end else begin
          if (!BTN_UP)                        hold_d = '0;
          else if (TICK && hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
          if (BTN_UP)    idle_d = '0;
          else if (TICK) idle_d = idle_q + 1'b1;
          if (mode_q == ST_SET_HOUR) begin
            hour_en_d   = field_pulse;
            disp_hour_d = field_pulse | (disp_hour_q ^ TICK);
          end else begin
            min_en_d    = field_pulse;
            disp_min_d  = field_pulse | (disp_min_q ^ TICK);
          end
        end
      end
      default: begin
        mode_d = ST_RUN;
        hold_d = '0;
        idle_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      mode_q      <= ST_RUN;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hour_en_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      disp_hour_q <= 1'b1;
      disp_min_q  <= 1'b1;
      // Seed edge history with live levels so a button held through reset is not an edge.
      mode_prev_q <= BTN_MODE;
      up_prev_q   <= BTN_UP;
      hold_q      <= '0;
      idle_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      sec_en_q    <= sec_en_d;
      min_en_q    <= min_en_d;
      hour_en_q   <= hour_en_d;
      sec_clr_q   <= sec_clr_d;
      disp_hour_q <= disp_hour_d;
      disp_min_q  <= disp_min_d;
      mode_prev_q <= mode_prev_d;
      up_prev_q   <= up_prev_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
    end
  end

  assign MODE         = mode_q;
  assign SEC_EN       = sec_en_q;
  assign MIN_EN       = min_en_q;
  assign HOUR_EN      = hour_en_q;
  assign SEC_CLR      = sec_clr_q;
  assign DISP_HOUR_ON = disp_hour_q;
  assign DISP_MIN_ON  = disp_min_q;

endmodule
